// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg: shared types and constants for the pipeline hazard scheduler.
// Forwarding select encodings, the "operand unused" Tuse marker, the scoreboard
// slot layout and the default mult/div busy lengths live here so the slot
// register, the scheduler top and the bench all agree on them.
package hazard_sched_pkg;

    // Forwarding select encodings shared by D and E operand muxes.
    localparam logic [1:0] FWD_RF = 2'd0;  // regfile / pipeline value
    localparam logic [1:0] FWD_E  = 2'd1;  // E stage result
    localparam logic [1:0] FWD_M  = 2'd2;  // M stage result
    localparam logic [1:0] FWD_W  = 2'd3;  // W stage result

    // Tuse value meaning "this operand is not read by the instruction".
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default busy windows of the mult/div unit, in cycles after issue.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // One scoreboard entry: what the instruction in a stage writes, how long
    // until its result exists, which sources it reads, and whether it is a
    // mult/div start.
    typedef struct packed {
        logic       we;      // writes a GPR (forced 0 when a3 == 0)
        logic [4:0] a3;      // destination register
        logic [1:0] tnew;    // cycles until the result is produced
        logic [4:0] rs;      // source register rs
        logic [4:0] rt;      // source register rt
        logic       md;      // mult/multu/div/divu start
        logic       md_div;  // with md: 1 = div, 0 = mult
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // Tnew counts down toward zero and stays there.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        logic [1:0] r;
        r = (t == 2'd0) ? 2'd0 : t - 2'd1;
        return r;
    endfunction

    // True when slot s produces a value for nonzero register r.
    function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
        logic hit;
        hit = s.we && (s.a3 == r) && (r != 5'd0);
        return hit;
    endfunction

    // D operand source: youngest stage whose result is already available.
    function automatic logic [1:0] d_fwd_sel(input slot_t e, input slot_t m,
                                             input slot_t w, input logic [4:0] r);
        logic [1:0] sel;
        if (writes_reg(e, r) && (e.tnew == 2'd0)) begin
            sel = FWD_E;
        end else if (writes_reg(m, r) && (m.tnew == 2'd0)) begin
            sel = FWD_M;
        end else if (writes_reg(w, r)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // E operand source: M result if ready, else W, else the value carried in.
    function automatic logic [1:0] e_fwd_sel(input slot_t m, input slot_t w,
                                             input logic [4:0] r);
        logic [1:0] sel;
        if (writes_reg(m, r) && (m.tnew == 2'd0)) begin
            sel = FWD_M;
        end else if (writes_reg(w, r)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// hazard_slot: one scoreboard slot register (E, M or W).
// Captures the entry from the previous stage each cycle, replaces it with an
// all-zero bubble when told to, and optionally saturating-decrements Tnew as
// the instruction moves one stage further down the pipe.
module hazard_slot
    import hazard_sched_pkg::*;
#(
    parameter bit DEC_TNEW = 1'b1   // 0 for the E slot: D supplies Tnew at E
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    slot_t nxt;

    // Next entry: normalise writes to $0 away, age Tnew, or insert a bubble.
    always_comb begin
        nxt = d;
        if (d.a3 == 5'd0) begin
            nxt.we = 1'b0;
        end
        if (DEC_TNEW) begin
            nxt.tnew = tnew_dec(d.tnew);
        end
        if (bubble) begin
            nxt = SLOT_EMPTY;
        end
    end

    // Slot register; reset empties the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SLOT_EMPTY;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: hazard scheduler for the five-stage MIPS pipeline.
// Tracks destination/Tnew of the instructions in E, M and W, compares them
// with the Tuse of the instruction in D, and drives the F/D enable, D/E
// bubble, operand forwarding selects and the mult/div busy window.
// Build option: define HAZARD_FWD_EN for forwarding with Tnew-based stalls;
// without it every fwd select is 0 and any E/M write to a used source stalls.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic       D_RegWrite,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_uses_md,
    output logic       stall,
    output logic       F_D_en,
    output logic       D_E_clear,
    output logic [1:0] D_fwd_rs,
    output logic [1:0] D_fwd_rt,
    output logic [1:0] E_fwd_rs,
    output logic [1:0] E_fwd_rt,
    output logic       E_md_start,
    output logic       md_busy
);

    slot_t      d_slot;
    slot_t      e_q;
    slot_t      m_q;
    slot_t      w_q;
    logic [3:0] md_cnt;
    logic       md_busy_i;
    logic       haz_rs;
    logic       haz_rt;
    logic       md_haz;
    logic       stall_i;

    // Register hazard on one D source against one in-flight slot.
    function automatic logic reg_haz(input slot_t s, input logic [4:0] r,
                                     input logic [1:0] tuse);
        logic h;
        h = 1'b0;
        if ((tuse != TUSE_NONE) && writes_reg(s, r)) begin
`ifdef HAZARD_FWD_EN
            // Forwarding covers the case where the value is ready by Tuse.
            h = (s.tnew > tuse);
`else
            // No bypass paths: only the regfile write in W can supply it.
            h = 1'b1;
`endif
        end
        return h;
    endfunction

    // Pack the D instruction into the entry it will occupy in E.
    always_comb begin
        d_slot        = SLOT_EMPTY;
        d_slot.we     = D_RegWrite;
        d_slot.a3     = D_A3;
        d_slot.tnew   = D_Tnew;
        d_slot.rs     = D_rs;
        d_slot.rt     = D_rt;
        d_slot.md     = D_md_start;
        d_slot.md_div = D_md_start & D_md_div;
    end

    // E takes D as-is (bubble when stalled); M and W age Tnew on entry.
    hazard_slot #(.DEC_TNEW(1'b0)) u_slot_e (
        .clk    (clk),
        .reset  (reset),
        .bubble (stall_i),
        .d      (d_slot),
        .q      (e_q)
    );

    hazard_slot #(.DEC_TNEW(1'b1)) u_slot_m (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (e_q),
        .q      (m_q)
    );

    hazard_slot #(.DEC_TNEW(1'b1)) u_slot_w (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (m_q),
        .q      (w_q)
    );

    // Mult/div busy counter: reload on a start in E, otherwise count down.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (e_q.md) begin
            md_cnt <= e_q.md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    // Hazard detection from the D operands and the registered slots.
    always_comb begin
        md_busy_i = (md_cnt != 4'd0);
        haz_rs    = reg_haz(e_q, D_rs, D_Tuse_rs) | reg_haz(m_q, D_rs, D_Tuse_rs);
        haz_rt    = reg_haz(e_q, D_rt, D_Tuse_rt) | reg_haz(m_q, D_rt, D_Tuse_rt);
        md_haz    = (D_uses_md | D_md_start) & (md_busy_i | e_q.md);
        stall_i   = haz_rs | haz_rt | md_haz;
    end

    // Pipeline register controls and mult/div status.
    always_comb begin
        stall      = stall_i;
        F_D_en     = ~stall_i;
        D_E_clear  = stall_i;
        E_md_start = e_q.md;
        md_busy    = md_busy_i;
    end

`ifdef HAZARD_FWD_EN
    // Forwarding selects for the D and E operand muxes.
    always_comb begin
        D_fwd_rs = d_fwd_sel(e_q, m_q, w_q, D_rs);
        D_fwd_rt = d_fwd_sel(e_q, m_q, w_q, D_rt);
        E_fwd_rs = e_fwd_sel(m_q, w_q, e_q.rs);
        E_fwd_rt = e_fwd_sel(m_q, w_q, e_q.rt);
    end
`else
    assign D_fwd_rs = FWD_RF;
    assign D_fwd_rt = FWD_RF;
    assign E_fwd_rs = FWD_RF;
    assign E_fwd_rt = FWD_RF;
`endif

    // W entry fields and E sources are only read on the forwarding build.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{w_q, e_q.rs, e_q.rt};

endmodule
